// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
//   Registered 1-to-NCH stream demultiplexer, NCH = 2**SEL_W. One holding
//   register sits between a single producer and NCH consumers. Each accepted
//   word is steered to one channel. The channel comes from `sel` in directed
//   mode, or from an internal round-robin pointer in round-robin mode.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = directed (use sel), 1 = round-robin
//   in_data    input payload
//   sel        target channel in directed mode
//   in_valid   producer has a word
//   in_ready   block can accept a word this cycle
//   out_data   held payload, shared by all channels
//   out_valid  one-hot, bit k = word pending for channel k
//   out_ready  per-channel consumer ready
//   cur_ch     channel of the held word
//   rr_ptr     next round-robin channel
//   xfer_cnt   number of words delivered (wraps)
// ---------------------------------------------------------------------------
module stream_demux #(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int NCH   = 2**SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [SEL_W-1:0]  cur_ch,
    output logic [SEL_W-1:0]  rr_ptr,
    output logic [CNT_W-1:0]  xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [NCH-1:0]      r_out_valid;
    logic [SEL_W-1:0]    r_cur_ch;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_xfer_cnt;

    logic                w_deliver;
    logic                w_in_ready;
    logic                w_accept;
    logic [SEL_W-1:0]    w_target;
    logic [NCH-1:0]      w_target_oh;

    // Only the ready bit of the held word's channel matters. All other
    // channels' ready bits are ignored.
    assign w_deliver = (r_state == FULL) && out_ready[r_cur_ch];

    // The register can take a new word when it is empty, or when it is
    // draining in this same cycle. That gives zero-bubble throughput.
    // The term never depends on in_valid. It is forced low while reset is
    // asserted, so nothing is accepted during reset.
    assign w_in_ready = !rst && ((r_state == EMPTY) || out_ready[r_cur_ch]);
    assign w_accept   = in_valid && w_in_ready;

    assign w_target    = mode ? r_rr_ptr : sel;
    assign w_target_oh = {{(NCH-1){1'b0}}, 1'b1} << w_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_data      <= '0;
            r_out_valid <= '0;
            r_cur_ch    <= '0;
            r_rr_ptr    <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            if (w_deliver)
                r_xfer_cnt <= r_xfer_cnt + 1'b1;

            if (w_accept) begin
                // This covers a load from EMPTY and a reload while draining.
                r_state     <= FULL;
                r_data      <= in_data;
                r_cur_ch    <= w_target;
                r_out_valid <= w_target_oh;
                // The pointer is SEL_W bits wide, so it wraps NCH-1 -> 0
                // by itself.
                if (mode)
                    r_rr_ptr <= r_rr_ptr + 1'b1;
            end else if (w_deliver) begin
                r_state     <= EMPTY;
                r_out_valid <= '0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_data;
    assign out_valid = r_out_valid;
    assign cur_ch    = r_cur_ch;
    assign rr_ptr    = r_rr_ptr;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
